trap_sequencer: RTL
===================

# trap_sequencer

Trap and interrupt sequencer for the pipelined RV32 core. Latches the external `interrupter` request and arbitrates it against synchronous exceptions and `mret` reported from the MEM stage. Drives one-cycle pipeline flush/redirect, CSR update strobes (mepc/mcause/mtval, MIE stacking) and a drain interlock that guarantees forward progress. Sits between the MEM stage, the CSR file and the IF-stage PC mux.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `EXT_IRQ_CODE`, 11, mcause code for the external interrupt

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `interrupter`  in  1  external interrupt request, level; rising edge latches pending
- `mstatus_mie`  in  1  global interrupt enable from CSR file
- `mie_meie`  in  1  external interrupt enable from CSR file
- `mtvec`  in  XLEN  trap vector; [1:0]=0 direct, =1 vectored, others treated as direct
- `mepc_in`  in  XLEN  current mepc, `mret` target
- `mem_valid`  in  1  MEM stage holds a valid, uncommitted instruction
- `mem_pc`  in  XLEN  PC of that instruction
- `stall_in`  in  1  pipeline stalled; no event accepted this cycle
- `exc_valid`  in  1  MEM instruction raised a synchronous exception
- `exc_code`  in  4  exception cause code
- `exc_tval`  in  XLEN  faulting address/instruction
- `mret_valid`  in  1  MEM instruction is `mret`
- `flush`  out  1  kill IF..MEM this cycle
- `redirect_valid`  out  1  load `redirect_pc` into PC
- `redirect_pc`  out  XLEN  new fetch address
- `csr_trap_we`  out  1  write mepc/mcause/mtval; MPIE<=MIE, MIE<=0
- `mepc_out`, `mcause_out`, `mtval_out`  out  XLEN  values for `csr_trap_we`
- `mie_restore`  out  1  MIE<=MPIE, MPIE<=1
- `irq_pending`  out  1  latched interrupt awaiting service

## Operation
- Registered state: `irq_prev`, `pend`, FSM {IDLE, DRAIN}.
- Edge detect: `edge = interrupter & ~irq_prev`. `pend <= edge | (pend & ~take_irq)`. Holding `interrupter` high yields one request.
- Event is accepted only when `mem_valid & ~stall_in`. Priority, highest first:
  1. `exc_valid`: mepc=`mem_pc`, mcause={0,exc_code} zero-extended, mtval=`exc_tval`, redirect=mtvec base ({mtvec[31:2],2'b00}). `csr_trap_we`, `flush`, `redirect_valid`. Next state DRAIN.
  2. `mret_valid`: redirect=`mepc_in`, `mie_restore`, `flush`, `redirect_valid`. Next state DRAIN.
  3. `take_irq` (= state IDLE & `pend` & `mstatus_mie` & `mie_meie`): MEM instruction is squashed, not committed. mepc=`mem_pc`, mcause={1,EXT_IRQ_CODE}, mtval=0, redirect=base (direct) or base+4*EXT_IRQ_CODE (vectored). `csr_trap_we`, `flush`, `redirect_valid`. `pend` clears. Next state DRAIN.
- DRAIN: interrupts blocked, exceptions and `mret` still accepted under the same rules. Exit to IDLE on the first cycle with `mem_valid & ~stall_in` and no accepted exception or `mret` (first handler/target instruction reaches MEM).
- Exception plus interrupt in the same cycle: exception wins. `pend` stays set and is taken after DRAIN exits, if enabled.
- Masked interrupt: `pend` and `irq_pending` are held indefinitely until enabled.
- Address arithmetic is modulo 2^XLEN.

## Timing
- All outputs are combinational (Mealy) from the current inputs and registered state. They are asserted for exactly the one cycle in which the event is accepted. State updates on the next rising edge.
- Minimum interrupt latency is two cycles: edge in cycle N latches `pend` at edge N+1, `take_irq` is possible in cycle N+1.
- Reset: `pend`=0, `irq_prev`=0, state=IDLE. While `rst`=1, every output is forced to 0. Reset in DRAIN returns to IDLE and drops a pending request.
- `stall_in`=1 suppresses all outputs. The event is re-evaluated each cycle until accepted.

## Test plan
- mtvec=0x100, MIE=MEIE=1, `interrupter` 0->1 with mem_pc=0x40 -> one cycle of flush/redirect_valid, redirect_pc=0x100, mepc_out=0x40, mcause_out=0x8000000B. `interrupter` held high afterwards -> no second trap.
- mtvec=0x101 (vectored), same stimulus -> redirect_pc=0x12C.
- exc_valid with code 2, mem_pc=0x80, tval=0xDEADBEEF, interrupt edge in the same cycle -> mcause_out=0x2, redirect 0x100, irq_pending stays 1. The interrupt is taken on the cycle after the first handler instruction (mem_valid) clears DRAIN.
- mret_valid with mepc_in=0x44 -> redirect_pc=0x44, mie_restore=1, csr_trap_we=0.
- mstatus_mie=0 with an edge -> irq_pending=1 and no trap for 20 cycles. Set MIE=1 -> trap within 1 cycle. stall_in=1 during the event -> outputs held low until the stall drops.
- Assert rst for 1 cycle while in DRAIN with pend=1 -> all outputs 0, irq_pending=0, next interrupt requires a new rising edge.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Signal bundle between the MEM stage / CSR file and the trap sequencer.
// The master side is the core; the slave side is the sequencer.
interface trap_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            interrupter;
   logic            mstatus_mie;
   logic            mie_meie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc_in;
   logic            mem_valid;
   logic [XLEN-1:0] mem_pc;
   logic            stall_in;
   logic            exc_valid;
   logic [3:0]      exc_code;
   logic [XLEN-1:0] exc_tval;
   logic            mret_valid;

   logic            flush;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            csr_trap_we;
   logic [XLEN-1:0] mepc_out;
   logic [XLEN-1:0] mcause_out;
   logic [XLEN-1:0] mtval_out;
   logic            mie_restore;
   logic            irq_pending;

   modport master (
      output interrupter, mstatus_mie, mie_meie, mtvec, mepc_in, mem_valid, mem_pc,
             stall_in, exc_valid, exc_code, exc_tval, mret_valid,
      input  flush, redirect_valid, redirect_pc, csr_trap_we, mepc_out, mcause_out,
             mtval_out, mie_restore, irq_pending
   );

   modport slave (
      input  interrupter, mstatus_mie, mie_meie, mtvec, mepc_in, mem_valid, mem_pc,
             stall_in, exc_valid, exc_code, exc_tval, mret_valid,
      output flush, redirect_valid, redirect_pc, csr_trap_we, mepc_out, mcause_out,
             mtval_out, mie_restore, irq_pending
   );
endinterface

// File: rtl/trap_sequencer.sv
// Trap/interrupt sequencer: arbitrates MEM-stage exceptions, mret and a latched
// external interrupt, and drives flush/redirect plus CSR trap strobes (Mealy outputs).
module trap_sequencer #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned EXT_IRQ_CODE = 11
) (
   input logic             clk,
   input logic             rst,
   trap_sequencer_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

   localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, (XLEN-1)'(EXT_IRQ_CODE)};
   localparam logic [XLEN-1:0] VEC_OFFSET = XLEN'(4 * EXT_IRQ_CODE);

   state_e          state_q, state_d;
   logic            pend_q, pend_d;
   logic            irq_prev_q, irq_prev_d;

   logic            accept;
   logic            irq_edge;
   logic            take_exc;
   logic            take_mret;
   logic            take_irq;
   logic [XLEN-1:0] trap_base;
   logic [XLEN-1:0] irq_target;

   // Event arbitration and next-state computation
   always_comb begin
      accept     = bus.mem_valid & ~bus.stall_in;
      irq_edge   = bus.interrupter & ~irq_prev_q;
      take_exc   = accept & bus.exc_valid;
      take_mret  = accept & ~bus.exc_valid & bus.mret_valid;
      take_irq   = accept & ~bus.exc_valid & ~bus.mret_valid & (state_q == IDLE) &
                   pend_q & bus.mstatus_mie & bus.mie_meie;
      trap_base  = {bus.mtvec[XLEN-1:2], 2'b00};
      irq_target = (bus.mtvec[1:0] == 2'b01) ? trap_base + VEC_OFFSET : trap_base;

      irq_prev_d = bus.interrupter;
      pend_d     = irq_edge | (pend_q & ~take_irq);
      state_d    = state_q;
      if (take_exc | take_mret | take_irq) begin
         state_d = DRAIN;
      end else if (accept) begin
         // first handler/target instruction reached MEM: forward progress guaranteed
         state_d = IDLE;
      end
   end

   // Outputs are valid only in the accepting cycle and are silenced by reset
   always_comb begin
      bus.flush          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.csr_trap_we    = 1'b0;
      bus.mepc_out       = '0;
      bus.mcause_out     = '0;
      bus.mtval_out      = '0;
      bus.mie_restore    = 1'b0;
      bus.irq_pending    = 1'b0;
      if (!rst) begin
         bus.irq_pending = pend_q;
         if (take_exc) begin
            bus.flush          = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = trap_base;
            bus.csr_trap_we    = 1'b1;
            bus.mepc_out       = bus.mem_pc;
            bus.mcause_out     = XLEN'(bus.exc_code);
            bus.mtval_out      = bus.exc_tval;
         end else if (take_mret) begin
            bus.flush          = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = bus.mepc_in;
            bus.mie_restore    = 1'b1;
         end else if (take_irq) begin
            bus.flush          = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = irq_target;
            bus.csr_trap_we    = 1'b1;
            bus.mepc_out       = bus.mem_pc;
            bus.mcause_out     = IRQ_CAUSE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pend_q     <= 1'b0;
         irq_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         irq_prev_q <= irq_prev_d;
      end
   end
endmodule
